// File: rtl/bsg_upstream_ch_if.sv
// Handshake/bus bundle for the BSG narrow-link upstream (transmit) channel.
//   core_data_in   : word from the core producer
//   core_valid_in  : word present
//   core_ready_out : channel can accept the word this cycle
//   io_data_out    : current serialized beat (registered)
//   io_valid_out   : beat valid (registered)
//   io_token_in    : one-cycle credit-return pulse from the remote channel
// master = the upstream channel itself, slave = its environment (core + pads).
interface bsg_upstream_ch_if #(
  parameter int CORE_W = 32,
  parameter int IO_W   = 8
);
  logic [CORE_W-1:0] core_data_in;
  logic              core_valid_in;
  logic              core_ready_out;
  logic [IO_W-1:0]   io_data_out;
  logic              io_valid_out;
  logic              io_token_in;

  modport master (
    input  core_data_in, core_valid_in, io_token_in,
    output core_ready_out, io_data_out, io_valid_out
  );

  modport slave (
    output core_data_in, core_valid_in, io_token_in,
    input  core_ready_out, io_data_out, io_valid_out
  );
endinterface

// File: rtl/bsg_upstream_ch.sv
// Transmit end of the BSG narrow link. Accepts CORE_W-bit words over a
// valid/ready handshake, serializes each into BEATS beats of IO_W bits
// (least-significant beat first) and paces words with a credit counter that
// the remote downstream channel replenishes with token pulses.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ch         : core/io handshake bundle (master side)
//   credit_cnt : credits (remote words of buffer space) currently available
//   credit_err : sticky, a token arrived while the counter was already full
// CORE_W must equal IO_W * BEATS, and the interface instance must be built
// with the same CORE_W/IO_W.
module bsg_upstream_ch #(
  parameter int CORE_W  = 32,
  parameter int IO_W    = 8,
  parameter int BEATS   = 4,
  parameter int CREDITS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  bsg_upstream_ch_if.master            ch,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                         credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CORE_W-1:0] shift_q, shift_d;
  logic [IO_W-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic ready;
  logic accept;

  // Ready looks at the registered count only, so a token landing while the
  // count is zero cannot open the gate in that same cycle.
  assign ready  = ((state_q == IDLE) || (beat_q == LAST_BEAT)) && (cnt_q != '0);
  assign accept = ch.core_valid_in && ready;

  // The shift register holds the not-yet-sent upper beats; the io register
  // is loaded one beat ahead so io_data_out is a clean flop output.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        data_d  = '0;
        valid_d = 1'b0;
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
          shift_d = ch.core_data_in;
          data_d  = ch.core_data_in[IO_W-1:0];
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          if (accept) begin
            // Reload on the last beat keeps io_valid_out continuous.
            beat_d  = '0;
            shift_d = ch.core_data_in;
            data_d  = ch.core_data_in[IO_W-1:0];
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            beat_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
          end
        end else begin
          beat_d  = beat_q + BW'(1);
          shift_d = shift_q >> IO_W;
          data_d  = shift_q[IO_W +: IO_W];
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        data_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Credit accounting: accept and token in the same cycle cancel out; a token
  // on a full counter is an overflow that holds the count and latches err.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept && !ch.io_token_in) begin
      cnt_d = cnt_q - CW'(1);
    end else if (!accept && ch.io_token_in) begin
      if (cnt_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= CRED_MAX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ch.core_ready_out = ready;
  assign ch.io_data_out    = data_q;
  assign ch.io_valid_out   = valid_q;
  assign credit_cnt        = cnt_q;
  assign credit_err        = err_q;

endmodule

// File: tb/tb_bsg_upstream_ch.sv
module tb_bsg_upstream_ch;

  logic clk;
  logic rst;

  bsg_upstream_ch_if #(.CORE_W(32), .IO_W(8)) ch1 ();
  bsg_upstream_ch_if #(.CORE_W(32), .IO_W(8)) ch2 ();

  logic [5:0] cnt1;
  logic       err1;
  logic [1:0] cnt2;
  logic       err2;

  bsg_upstream_ch #(.CORE_W(32), .IO_W(8), .BEATS(4), .CREDITS(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ch         (ch1),
    .credit_cnt (cnt1),
    .credit_err (err1)
  );

  bsg_upstream_ch #(.CORE_W(32), .IO_W(8), .BEATS(4), .CREDITS(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .ch         (ch2),
    .credit_cnt (cnt2),
    .credit_err (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ch1.core_valid_in = 1'b0; ch1.core_data_in = '0; ch1.io_token_in = 1'b0;
    ch2.core_valid_in = 1'b0; ch2.core_data_in = '0; ch2.io_token_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] words [3];
  logic        found;

  initial begin
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC;

    // Reset state
    do_reset();
    check("rst_ready", ch1.core_ready_out, 1);
    check("rst_valid", ch1.io_valid_out, 0);
    check("rst_data",  ch1.io_data_out, 0);
    check("rst_cnt",   cnt1, 32);
    check("rst_err",   err1, 0);

    // Single word
    ch1.core_data_in = 32'hDDCCBBAA;
    ch1.core_valid_in = 1'b1;
    @(negedge clk);
    ch1.core_valid_in = 1'b0;
    ch1.core_data_in = 32'hFFFFFFFF;
    check("one_b0_ready", ch1.core_ready_out, 0);
    check("one_cnt", cnt1, 31);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("one_valid%0d", k), ch1.io_valid_out, 1);
      check($sformatf("one_data%0d", k), ch1.io_data_out, byte_of(32'hDDCCBBAA, k));
    end
    @(negedge clk);
    check("one_valid_end", ch1.io_valid_out, 0);
    check("one_data_end", ch1.io_data_out, 0);

    // Three back-to-back words, junk data while not ready
    do_reset();
    ch1.core_data_in = words[0];
    ch1.core_valid_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("b2b_valid%0d", i), ch1.io_valid_out, 1);
      check($sformatf("b2b_data%0d", i), ch1.io_data_out, byte_of(words[i/4], i%4));
      check($sformatf("b2b_ready%0d", i), ch1.core_ready_out, ((i % 4) == 3) ? 1 : 0);
      if (i == 3)       ch1.core_data_in = words[1];
      else if (i == 7)  ch1.core_data_in = words[2];
      else if (i == 11) ch1.core_valid_in = 1'b0;
      else              ch1.core_data_in = $urandom;
    end
    @(negedge clk);
    check("b2b_valid_end", ch1.io_valid_out, 0);
    check("b2b_cnt", cnt1, 29);

    // Credit exhaustion on the CREDITS=2 instance
    do_reset();
    ch2.core_data_in = words[0];
    ch2.core_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("cr_valid%0d", i), ch2.io_valid_out, 1);
      check($sformatf("cr_data%0d", i), ch2.io_data_out, byte_of(words[i/4], i%4));
      if (i == 3) ch2.core_data_in = words[1];
      if (i == 7) ch2.core_data_in = words[2];
    end
    check("cr_ready_last", ch2.core_ready_out, 0);
    check("cr_cnt_last", cnt2, 0);
    @(negedge clk);
    check("cr_idle_valid", ch2.io_valid_out, 0);
    check("cr_idle_ready", ch2.core_ready_out, 0);
    check("cr_idle_cnt", cnt2, 0);
    ch2.io_token_in = 1'b1;
    @(negedge clk);
    ch2.io_token_in = 1'b0;
    check("cr_tok_cnt", cnt2, 1);
    check("cr_tok_ready", ch2.core_ready_out, 1);
    check("cr_tok_valid", ch2.io_valid_out, 0);
    @(negedge clk);
    ch2.core_valid_in = 1'b0;
    check("cr_w2_cnt", cnt2, 0);
    check("cr_w2_valid", ch2.io_valid_out, 1);
    check("cr_w2_data", ch2.io_data_out, byte_of(words[2], 0));
    check("cr_err", err2, 0);
    repeat (4) @(negedge clk);

    // Accept and token together at credit_cnt == 5
    do_reset();
    ch1.core_data_in = 32'h5A5A5A5A;
    ch1.core_valid_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ch1.core_ready_out && cnt1 == 5) begin
        found = 1'b1;
        break;
      end
    end
    check("sim_reach5", found, 1);
    if (found) begin
      ch1.io_token_in = 1'b1;
      @(negedge clk);
      ch1.io_token_in = 1'b0;
      ch1.core_valid_in = 1'b0;
      check("sim_cnt", cnt1, 5);
      check("sim_valid", ch1.io_valid_out, 1);
      check("sim_data", ch1.io_data_out, 8'h5A);
    end
    ch1.core_valid_in = 1'b0;
    repeat (5) @(negedge clk);

    // Token overflow with no traffic
    do_reset();
    ch1.io_token_in = 1'b1;
    @(negedge clk);
    ch1.io_token_in = 1'b0;
    check("ovf_cnt", cnt1, 32);
    check("ovf_err", err1, 1);
    repeat (3) @(negedge clk);
    check("ovf_err_sticky", err1, 1);
    do_reset();
    check("ovf_err_cleared", err1, 0);

    // Asynchronous reset during beat 2
    ch1.core_data_in = 32'hA1B2C3D4;
    ch1.core_valid_in = 1'b1;
    @(negedge clk);
    ch1.core_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_pre_valid", ch1.io_valid_out, 1);
    check("ar_pre_data", ch1.io_data_out, 8'hB2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", ch1.io_valid_out, 0);
    check("ar_cnt", cnt1, 32);
    @(negedge clk);
    rst = 1'b0;
    ch1.core_data_in = 32'h01020304;
    ch1.core_valid_in = 1'b1;
    @(negedge clk);
    ch1.core_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("ar_new_valid%0d", k), ch1.io_valid_out, 1);
      check($sformatf("ar_new_data%0d", k), ch1.io_data_out, byte_of(32'h01020304, k));
    end
    @(negedge clk);
    check("ar_new_end", ch1.io_valid_out, 0);
    check("ar_new_cnt", cnt1, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
